// File: rtl/spike_raster_pkg.sv
// Shared types and constants for the spike raster packer.
// Holds the header tag, frame counter width and packer states.
package spike_raster_pkg;

    localparam logic [3:0] HDR_TAG = 4'hA;
    localparam int FRAME_CNT_W = 12;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } pack_state_t;

endpackage

// File: rtl/spike_raster_packer_if.sv
// Spike input stream and pipe-out bundle for the raster packer.
// The slave side is the packer, the master side is the neuron pipeline and host.
interface spike_raster_packer_if
    import spike_raster_pkg::*;
#(
    parameter int NN = 8,
    parameter int CW = 11
);
    logic                   spike_valid;
    logic [NN-1:0]          neuron_index;
    logic                   spike;
    logic                   rd_en;
    logic [15:0]            dout;
    logic                   block_ready;
    logic [CW-1:0]          word_count;
    logic                   overflow;
    logic                   seq_err;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    modport master (
        output spike_valid, neuron_index, spike, rd_en,
        input  dout, block_ready, word_count,
        input  overflow, seq_err, frame_cnt
    );

    modport slave (
        input  spike_valid, neuron_index, spike, rd_en,
        output dout, block_ready, word_count,
        output overflow, seq_err, frame_cnt
    );
endinterface

// File: rtl/spike_fifo16.sv
// 16-bit synchronous FIFO with registered read port.
// Storage has no reset so it maps onto block RAM.
module spike_fifo16 #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [15:0]              wdata,
    input  logic                     pop,
    output logic [15:0]              rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          empty;
    logic          wr;
    logic          rd;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    // full is judged before any same-cycle pop
    assign wr    = push && !full;
    assign rd    = pop && !empty;

    always_ff @(posedge clk) begin
        if (wr && !clear) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            rdata <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            rdata <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + 1'b1;
            end
            if (rd) begin
                rptr  <= rptr + 1'b1;
                rdata <= mem[rptr];
            end else if (pop) begin
                rdata <= '0;
            end
            if (wr && !rd) begin
                count <= count + 1'b1;
            end else if (rd && !wr) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_raster_packer.sv
// Packs neuron spike bits into 16-bit raster words with frame headers
// and buffers them for the pipe-out endpoint.
module spike_raster_packer
    import spike_raster_pkg::*;
#(
    parameter int NN          = 8,
    parameter int DEPTH       = 1024,
    parameter int BLOCK_WORDS = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    spike_raster_packer_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] BLK = CW'(BLOCK_WORDS);
    localparam logic [NN-1:0] ONE = NN'(1);

    pack_state_t            state;
    pack_state_t            state_n;
    logic [NN-1:0]          exp_idx;
    logic [NN-1:0]          exp_n;
    logic [15:0]            shift;
    logic [15:0]            shift_n;
    logic [15:0]            merged;
    logic [FRAME_CNT_W-1:0] fcnt;
    logic [FRAME_CNT_W-1:0] fcnt_n;
    logic                   push;
    logic [15:0]            push_word;
    logic                   seq_set;
    logic                   full;
    logic [CW-1:0]          count;
    logic                   ovf;
    logic                   err;
    logic                   is_hdr;
    logic                   is_ok;
    logic                   is_bad;

    assign is_hdr = bus.spike_valid
                 && (bus.neuron_index == '0);
    assign is_ok  = bus.spike_valid && !is_hdr
                 && (state == RUN)
                 && (bus.neuron_index == exp_idx);
    assign is_bad = bus.spike_valid && !is_hdr
                 && (state == RUN)
                 && (bus.neuron_index != exp_idx);

    always_comb begin
        state_n   = state;
        exp_n     = exp_idx;
        shift_n   = shift;
        fcnt_n    = fcnt;
        push      = 1'b0;
        push_word = shift;
        seq_set   = 1'b0;
        merged    = shift;
        merged[bus.neuron_index[3:0]] = bus.spike;
        unique case (1'b1)
            is_hdr: begin
                push      = 1'b1;
                push_word = {HDR_TAG, fcnt};
                fcnt_n    = fcnt + 1'b1;
                shift_n   = {15'd0, bus.spike};
                exp_n     = ONE;
                state_n   = RUN;
            end
            is_ok: begin
                shift_n = merged;
                exp_n   = exp_idx + ONE;
                if (bus.neuron_index[3:0] == 4'hF) begin
                    push      = 1'b1;
                    push_word = merged;
                    shift_n   = '0;
                end
            end
            is_bad: begin
                seq_set = 1'b1;
                shift_n = '0;
                state_n = SYNC;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= SYNC;
            exp_idx <= '0;
            shift   <= '0;
            fcnt    <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else if (clear) begin
            state   <= SYNC;
            exp_idx <= '0;
            shift   <= '0;
            fcnt    <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            exp_idx <= exp_n;
            shift   <= shift_n;
            fcnt    <= fcnt_n;
            ovf     <= ovf | (push & full);
            err     <= err | seq_set;
        end
    end

    spike_fifo16 #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .clear (clear),
        .push  (push),
        .wdata (push_word),
        .pop   (bus.rd_en),
        .rdata (bus.dout),
        .count (count),
        .full  (full)
    );

    assign bus.word_count  = count;
    assign bus.block_ready = (count >= BLK);
    assign bus.overflow    = ovf;
    assign bus.seq_err     = err;
    assign bus.frame_cnt   = fcnt;

endmodule

// File: tb/tb_spike_raster_packer.sv
// Randomized scoreboard bench for spike_raster_packer against a
// frame-level reference model (NN=8, DEPTH=64, BLOCK_WORDS=32).
module tb_spike_raster_packer;
    import spike_raster_pkg::*;

    localparam int NN    = 8;
    localparam int NIDX  = 1 << NN;
    localparam int DEPTH = 64;
    localparam int BW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;

    spike_raster_packer_if #(.NN(NN), .CW(CW)) bus ();

    spike_raster_packer #(
        .NN          (NN),
        .DEPTH       (DEPTH),
        .BLOCK_WORDS (BW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] mq[$];
    logic [15:0] sb[$];
    int m_fc;
    bit m_run;
    int m_next;
    bit m_bits[NIDX];
    bit m_ovf;
    bit m_err;

    task automatic check(string name, logic [31:0] got,
                         logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h t=%0t",
                     name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_fc = 0;
        m_run = 0;
        m_next = 0;
        foreach (m_bits[k]) m_bits[k] = 0;
        m_ovf = 0;
        m_err = 0;
    endfunction

    // One cycle of the packer as described by the frame rules.
    function automatic void step(bit v, int idx, bit s, bit rd);
        bit has = 0;
        bit full;
        logic [15:0] w = '0;
        if (v) begin
            if (idx == 0) begin
                w = 16'(32'hA000 | m_fc);
                has = 1;
                m_fc = (m_fc + 1) % 4096;
                foreach (m_bits[k]) m_bits[k] = 0;
                m_bits[0] = s;
                m_run = 1;
                m_next = 1;
            end else if (m_run) begin
                if (idx == m_next) begin
                    m_bits[idx] = s;
                    m_next = (idx + 1) % NIDX;
                    if (idx % 16 == 15) begin
                        for (int k = 0; k < 16; k++)
                            w[k] = m_bits[idx - 15 + k];
                        has = 1;
                    end
                end else begin
                    m_err = 1;
                    m_run = 0;
                end
            end
        end
        full = (mq.size() == DEPTH);
        if (rd) sb.push_back(mq.size() > 0 ? mq.pop_front() : 16'h0);
        if (has) begin
            if (full) m_ovf = 1;
            else mq.push_back(w);
        end
    endfunction

    task automatic cyc(bit v, int idx, bit s, bit rd);
        @(negedge clk);
        check("word_count", 32'(bus.word_count), mq.size());
        check("block_ready", 32'(bus.block_ready),
              32'(mq.size() >= BW));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        check("seq_err", 32'(bus.seq_err), 32'(m_err));
        check("frame_cnt", 32'(bus.frame_cnt), m_fc);
        bus.spike_valid  = v;
        bus.neuron_index = NN'(idx);
        bus.spike        = s;
        bus.rd_en        = rd;
        step(v, idx, s, rd);
    endtask

    task automatic upd(int idx, bit s, int rdpct, int gappct);
        while ($urandom_range(99) < gappct)
            cyc(0, $urandom_range(NIDX - 1), 1'($urandom),
                $urandom_range(99) < rdpct);
        cyc(1, idx, s, $urandom_range(99) < rdpct);
    endtask

    task automatic frame(int rdpct, int gappct);
        for (int i = 0; i < NIDX; i++)
            upd(i, 1'($urandom), rdpct, gappct);
    endtask

    task automatic drain();
        while (mq.size() > 0) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
    endtask

    logic rd_d;
    logic clr_d;
    logic [15:0] hold;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_d  <= 1'b0;
            clr_d <= 1'b0;
        end else begin
            rd_d  <= bus.rd_en && !clear;
            clr_d <= clear;
        end
    end

    initial begin
        hold = '0;
        forever begin
            @(negedge clk);
            if (!reset_n || clr_d) begin
                hold = '0;
            end else if (rd_d) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty dout %0h", bus.dout);
                end else begin
                    hold = sb.pop_front();
                end
            end
            check("dout", 32'(bus.dout), 32'(hold));
        end
    end

    initial begin
        bus.spike_valid  = 0;
        bus.neuron_index = '0;
        bus.spike        = 0;
        bus.rd_en        = 0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1;

        // async reset mid-frame with 5 words held
        for (int i = 0; i < 80; i++) upd(i, 1'($urandom), 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        #2 reset_n = 0;
        #1;
        check("rst_count", 32'(bus.word_count), 0);
        check("rst_dout", 32'(bus.dout), 0);
        check("rst_ovf", 32'(bus.overflow), 0);
        check("rst_err", 32'(bus.seq_err), 0);
        check("rst_fcnt", 32'(bus.frame_cnt), 0);
        check("rst_blk", 32'(bus.block_ready), 0);
        model_reset();
        sb.delete();
        @(negedge clk);
        reset_n = 1;

        // single frame, spikes on 0, 17, 255
        for (int i = 0; i < NIDX; i++)
            upd(i, i == 0 || i == 17 || i == 255, 0, 30);
        cyc(0, 0, 0, 0);
        check("f1_count", 32'(bus.word_count), 17);
        check("f1_fcnt", 32'(bus.frame_cnt), 1);
        drain();

        // three frames then back-to-back readout past empty
        repeat (3) frame(0, 20);
        for (int i = 0; i < 54; i++) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);

        // order error, ignored tail, resync
        for (int i = 0; i <= 20; i++) upd(i, 1'($urandom), 0, 0);
        upd(40, 1, 0, 0);
        for (int i = 41; i < NIDX; i++) upd(i, 1'($urandom), 0, 10);
        frame(30, 10);
        drain();

        // overflow: four frames with no reads
        repeat (4) frame(0, 5);
        cyc(0, 0, 0, 0);
        check("ovf_count", 32'(bus.word_count), DEPTH);
        drain();
        frame(0, 5);
        drain();

        // full FIFO: header push with same-cycle pop
        repeat (4) frame(0, 0);
        cyc(1, 0, 1, 1);
        cyc(0, 0, 0, 0);
        check("full_pop", 32'(bus.word_count), DEPTH - 1);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        clear = 1;
        bus.spike_valid  = 1;
        bus.neuron_index = '0;
        bus.spike        = 1;
        model_reset();
        @(negedge clk);
        clear = 0;
        bus.spike_valid = 0;
        cyc(0, 0, 0, 0);

        // random mix of streams, jumps and reads
        begin
            int idx = 0;
            for (int n = 0; n < 3000; n++) begin
                bit v = $urandom_range(99) < 80;
                if ($urandom_range(99) < 2)
                    idx = $urandom_range(NIDX - 1);
                cyc(v, idx, 1'($urandom),
                    $urandom_range(99) < 35);
                if (v) idx = (idx + 1) % NIDX;
            end
        end
        drain();
        check("sb_left", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
